// File: rtl/note_scheduler.sv
// Beat-driven note sequencer: divides the clock into beats, maps LFSR samples to
// lanes under a max-repeat rule, and queues notes for the sprite spawner.
module note_scheduler #(
    parameter int unsigned BEAT_DIV   = 12_500_000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_REPEAT = 2
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    input  logic [2:0]  rnd,
    output logic        beat,
    output logic        spawn_valid,
    output logic [4:0]  spawn_lane,
    input  logic        spawn_ready,
    output logic        overflow,
    output logic [15:0] notes_spawned,
    output logic [1:0]  state
);

    localparam int unsigned CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned RW = $clog2(MAX_REPEAT + 1);
    localparam logic [2:0]  LANE_NONE = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t        st, st_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          beat_next;
    logic [2:0]    last_lane, last_next, lane_sel;
    logic [RW-1:0] rep, rep_next;
    logic          push, clear_stats;

    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, pop, wr_en, drop;

    assign state       = st;
    assign spawn_valid = (wr_ptr != rd_ptr);
    assign spawn_lane  = spawn_valid ? mem[rd_ptr[AW-1:0]] : 5'd0;
    assign full        = ((wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH));
    assign pop         = spawn_valid && spawn_ready;
    assign wr_en       = push && (!full || pop);
    assign drop        = push && full && !pop;

    // Next state, beat phase and lane selection with repeat limiting
    always_comb begin
        st_next     = st;
        cnt_next    = cnt;
        beat_next   = 1'b0;
        push        = 1'b0;
        lane_sel    = 3'd0;
        last_next   = last_lane;
        rep_next    = rep;
        clear_stats = 1'b0;

        case (st)
            IDLE:    if (!stop && !pause && start) begin
                         st_next     = RUN;
                         clear_stats = 1'b1;
                     end
            RUN:     if (stop)        st_next = IDLE;
                     else if (pause)  st_next = PAUSED;
            PAUSED:  if (stop)        st_next = IDLE;
                     else if (!pause) st_next = RUN;
            default: st_next = IDLE;
        endcase

        // A beat already on the output completes even if pause arrives with it
        if (st_next == IDLE)
            cnt_next = '0;
        else if (st == RUN && (!pause || beat))
            cnt_next = (cnt == CW'(BEAT_DIV - 1)) ? '0 : cnt + CW'(1);
        beat_next = (st_next == RUN) && (cnt_next == CW'(BEAT_DIV - 1));

        if (beat && !stop && rnd < 3'd5) begin
            push     = 1'b1;
            lane_sel = rnd;
            if (rnd == last_lane && rep == RW'(MAX_REPEAT)) begin
                lane_sel = (rnd == 3'd4) ? 3'd0 : rnd + 3'd1;
                rep_next = RW'(1);
            end else begin
                rep_next = (rnd == last_lane) ? rep + RW'(1) : RW'(1);
            end
            last_next = lane_sel;
        end

        if (st_next == IDLE) begin
            last_next = LANE_NONE;
            rep_next  = '0;
        end
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            st            <= IDLE;
            cnt           <= '0;
            beat          <= 1'b0;
            last_lane     <= LANE_NONE;
            rep           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            overflow      <= 1'b0;
            notes_spawned <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
        end else begin
            st        <= st_next;
            cnt       <= cnt_next;
            beat      <= beat_next;
            last_lane <= last_next;
            rep       <= rep_next;

            if (stop) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) begin
                    mem[wr_ptr[AW-1:0]] <= 5'b00001 << lane_sel;
                    wr_ptr              <= wr_ptr + (AW+1)'(1);
                end
                if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            end

            if (clear_stats)  overflow <= 1'b0;
            else if (drop)    overflow <= 1'b1;

            if (clear_stats)
                notes_spawned <= '0;
            else if (pop && notes_spawned != 16'hFFFF)
                notes_spawned <= notes_spawned + 16'd1;
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Scoreboard bench for note_scheduler: stimulus queues expected lanes, a monitor
// pops and compares them on every spawn handshake.
module tb_note_scheduler;

    logic        Clk = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0, pause = 1'b0, stop = 1'b0, spawn_ready = 1'b0;
    logic [2:0]  rnd = 3'd0;
    logic        beat, spawn_valid, overflow;
    logic [4:0]  spawn_lane;
    logic [15:0] notes_spawned;
    logic [1:0]  state;

    int compared = 0, mismatched = 0;
    logic [4:0] exp_q [$];

    localparam logic [4:0] G = 5'b00001, R = 5'b00010, Y = 5'b00100,
                           B = 5'b01000, O = 5'b10000;

    note_scheduler #(.BEAT_DIV(4), .FIFO_DEPTH(4), .MAX_REPEAT(2)) dut (
        .Clk(Clk), .RESET(RESET), .start(start), .pause(pause), .stop(stop),
        .rnd(rnd), .beat(beat), .spawn_valid(spawn_valid), .spawn_lane(spawn_lane),
        .spawn_ready(spawn_ready), .overflow(overflow),
        .notes_spawned(notes_spawned), .state(state)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Drive rnd from the cycle after the previous beat, wait for the next beat,
    // check its spacing and queue the expected lane (0 = nothing enters the queue)
    task automatic beat_with(input logic [2:0] v, input int gap, input logic [4:0] lane);
        int n;
        step();
        rnd = v;
        n = 1;
        while (beat !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("beat_gap", n, gap);
        if (lane != 5'd0) exp_q.push_back(lane);
    endtask

    always @(negedge Clk) begin
        if (!RESET) begin
            if (spawn_valid && spawn_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_pop: got lane %b expected no note at %0t",
                             spawn_lane, $time);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    chk("pop_lane", spawn_lane, e);
                end
            end else if (!spawn_valid) begin
                chk("idle_lane_zero", spawn_lane, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        bit seen_beat;

        step(); step();
        chk("rst_state", state, 0);
        chk("rst_beat", beat, 0);
        chk("rst_valid", spawn_valid, 0);
        chk("rst_lane", spawn_lane, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_notes", notes_spawned, 0);
        RESET = 1'b0;
        step();

        // Beat cadence and rest
        rnd = 3'd1; spawn_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("state_run", state, 1);
        beat_with(3'd1, 3, R);
        beat_with(3'd1, 4, R);
        beat_with(3'd6, 4, 5'd0);
        step();
        chk("rest_no_valid", spawn_valid, 0);
        chk("notes_after_cadence", notes_spawned, 2);

        // Repeat limit: G,G,R,G
        beat_with(3'd0, 3, G);
        beat_with(3'd0, 4, G);
        beat_with(3'd0, 4, R);
        beat_with(3'd0, 4, G);
        step(); step();
        chk("notes_after_repeat", notes_spawned, 6);
        spawn_ready = 1'b0;

        // Overflow: B,B,O,B queued; fifth B dropped
        beat_with(3'd3, 2, B);
        beat_with(3'd3, 4, B);
        beat_with(3'd3, 4, O);
        beat_with(3'd3, 4, B);
        chk("no_overflow_at_4", overflow, 0);
        beat_with(3'd3, 4, 5'd0);
        step();
        chk("overflow_set", overflow, 1);
        chk("head_held_valid", spawn_valid, 1);
        chk("head_held_lane", spawn_lane, B);
        chk("notes_while_blocked", notes_spawned, 6);
        rnd = 3'd6; spawn_ready = 1'b1;
        repeat (5) step();
        chk("drained_valid", spawn_valid, 0);
        chk("drained_notes", notes_spawned, 10);
        chk("overflow_sticky", overflow, 1);
        chk("drained_queue", exp_q.size(), 0);

        // Pause at beat counter 2 for 10 cycles, queued note drains meanwhile
        spawn_ready = 1'b0;
        beat_with(3'd4, 2, O);
        step();
        rnd = 3'd6;
        step(); step();
        pause = 1'b1;
        step();
        chk("state_paused", state, 2);
        seen_beat = beat;
        spawn_ready = 1'b1;
        repeat (9) begin
            step();
            if (beat) seen_beat = 1'b1;
        end
        chk("no_beat_in_pause", seen_beat, 0);
        chk("pause_drained", exp_q.size(), 0);
        chk("pause_notes", notes_spawned, 11);
        pause = 1'b0;
        beat_with(3'd6, 2, 5'd0);

        // Stop with three notes queued, on a beat cycle
        spawn_ready = 1'b0;
        beat_with(3'd2, 4, Y);
        beat_with(3'd2, 4, Y);
        beat_with(3'd2, 4, B);
        step(); step(); step();
        rnd = 3'd0;
        step();
        chk("beat_at_stop", beat, 1);
        stop = 1'b1;
        exp_q.delete();
        step();
        stop = 1'b0;
        chk("stop_valid", spawn_valid, 0);
        chk("stop_state", state, 0);
        chk("stop_lane", spawn_lane, 0);
        step();
        chk("stop_no_late_push", spawn_valid, 0);

        // Restart clears stats and repeat tracking
        start = 1'b1; spawn_ready = 1'b1;
        step();
        start = 1'b0;
        chk("restart_state", state, 1);
        chk("restart_overflow", overflow, 0);
        chk("restart_notes", notes_spawned, 0);
        beat_with(3'd3, 3, B);
        beat_with(3'd3, 4, B);
        beat_with(3'd3, 4, O);
        step(); step();
        chk("restart_count", notes_spawned, 3);

        // Asynchronous reset while a note is pending
        spawn_ready = 1'b0;
        beat_with(3'd1, 2, R);
        step();
        chk("pre_reset_valid", spawn_valid, 1);
        RESET = 1'b1;
        #1;
        chk("async_rst_valid", spawn_valid, 0);
        chk("async_rst_lane", spawn_lane, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_notes", notes_spawned, 0);
        chk("async_rst_beat", beat, 0);
        exp_q.delete();
        step();
        RESET = 1'b0;
        step();
        chk("post_rst_state", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
